// File: rtl/tie_bank_if.sv
// tie_bank_if: write port, lock control and tie/status outputs of tie_bank.
// Ports: iWrValid/oWrReady/iWrChannel/iWrData/oWrErr (shadow write port),
//        iLock/oLocked (sticky lock), oSeqDone/oTie (release status, tie buses).
interface tie_bank_if #(
   parameter int WIDTH = 8,
   parameter int CH    = 4
);
   logic                oWrReady;
   logic                iWrValid;
   logic [3:0]          iWrChannel;
   logic [WIDTH-1:0]    iWrData;
   logic                oWrErr;
   logic                iLock;
   logic                oLocked;
   logic                oSeqDone;
   logic [CH*WIDTH-1:0] oTie;

   // master drives requests (testbench / config agent), slave is the tie bank
   modport master (
      output iWrValid, iWrChannel, iWrData, iLock,
      input  oWrReady, oWrErr, oLocked, oSeqDone, oTie
   );
   modport slave (
      input  iWrValid, iWrChannel, iWrData, iLock,
      output oWrReady, oWrErr, oLocked, oSeqDone, oTie
   );
endinterface

// File: rtl/tie_bank.sv
// tie_bank: CH constant tie buses, held at RST_VAL then released one by one to programmable shadows.
// Latency: accepted write to a released channel shows on oTie the next cycle; release shows the cycle after its edge.
// Backpressure: oWrReady is high whenever unlocked, so writes are taken every cycle until oLocked is set.
//
// Ports: iClock/iReset (sync, active-high); bus (tie_bank_if.slave): write port
//        iWrValid/oWrReady/iWrChannel/iWrData/oWrErr, lock iLock/oLocked,
//        oSeqDone, oTie (channel i = oTie[i*WIDTH +: WIDTH]).
// Optional: define TIE_BANK_PARITY_EN to add oParity[CH-1:0], the registered
//           XOR reduction of each oTie channel.
module tie_bank #(
   parameter int               WIDTH    = 8,
   parameter int               CH       = 4,
   parameter logic [WIDTH-1:0] RST_VAL  = '0,
   parameter logic [WIDTH-1:0] INIT_VAL = '0,
   parameter int               STAGGER  = 16
) (
   input  logic          iClock,
   input  logic          iReset,
`ifdef TIE_BANK_PARITY_EN
   output logic [CH-1:0] oParity,
`endif
   tie_bank_if.slave     bus
);

   // Counter saturates at STAGGER*CH, at most 255*16 = 4080.
   localparam int CNT_W   = 12;
   localparam int CNT_MAX = STAGGER * CH;

   typedef enum logic {
      ST_SEQ,   // releasing channels on the staggered schedule
      ST_RUN    // all channels released, counter frozen
   } state_t;

   state_t              st_q, st_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CH-1:0]       rel_q, rel_d;
   logic [WIDTH-1:0]    shadow_q [CH];
   logic [WIDTH-1:0]    shadow_d [CH];
   logic [CH*WIDTH-1:0] tie_d;
   logic                wr_acc;
   logic                wr_in_range;
   logic                locked_d;

   // Ready was registered high in the previous cycle, so a write arriving
   // together with iLock is still taken.
   assign wr_acc      = bus.iWrValid & bus.oWrReady;
   assign wr_in_range = int'(bus.iWrChannel) < CH;
   assign locked_d    = bus.oLocked | bus.iLock;

   // Next-state: release schedule, shadow update and the next oTie image.
   always_comb begin
      st_d     = st_q;
      cnt_d    = cnt_q;
      rel_d    = rel_q;
      shadow_d = shadow_q;
      tie_d    = '0;

      if (st_q == ST_SEQ) begin
         if (cnt_q != CNT_W'(CNT_MAX))
            cnt_d = cnt_q + 1'b1;
         // Channel i releases on the edge where the counter reads
         // STAGGER*(i+1)-1; a zero stagger releases everything at once.
         for (int i = 0; i < CH; i++) begin
            if (STAGGER == 0 || cnt_q == CNT_W'(STAGGER * (i + 1) - 1))
               rel_d[i] = 1'b1;
         end
         if (&rel_d)
            st_d = ST_RUN;
      end

      // Out-of-range channels match no entry and leave the shadows alone.
      if (wr_acc) begin
         for (int i = 0; i < CH; i++) begin
            if (bus.iWrChannel == 4'(i))
               shadow_d[i] = bus.iWrData;
         end
      end

      // Built from next-state so a write landing on the release edge wins.
      for (int i = 0; i < CH; i++)
         tie_d[i*WIDTH +: WIDTH] = rel_d[i] ? shadow_d[i] : RST_VAL;
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         st_q         <= ST_SEQ;
         cnt_q        <= '0;
         rel_q        <= '0;
         for (int i = 0; i < CH; i++)
            shadow_q[i] <= INIT_VAL;
         bus.oTie     <= {CH{RST_VAL}};
         bus.oWrReady <= 1'b0;
         bus.oWrErr   <= 1'b0;
         bus.oLocked  <= 1'b0;
         bus.oSeqDone <= 1'b0;
      end else begin
         st_q         <= st_d;
         cnt_q        <= cnt_d;
         rel_q        <= rel_d;
         shadow_q     <= shadow_d;
         bus.oTie     <= tie_d;
         bus.oWrReady <= !locked_d;
         bus.oWrErr   <= wr_acc & !wr_in_range;
         bus.oLocked  <= locked_d;
         bus.oSeqDone <= &rel_d;
      end
   end

`ifdef TIE_BANK_PARITY_EN
   // Registered from the same next image as oTie so the two never disagree.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         oParity <= {CH{^RST_VAL}};
      end else begin
         for (int i = 0; i < CH; i++)
            oParity[i] <= ^tie_d[i*WIDTH +: WIDTH];
      end
   end
`endif

endmodule

// File: tb/tb_tie_bank.sv
// tb_tie_bank: directed checks of tie_bank release sequencing, write port,
// error pulse, lock and mid-sequence reset (STAGGER=16), plus a STAGGER=0 instance.
module tb_tie_bank;
   localparam int W = 8;
   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;
   int   total = 0;
   int   bad   = 0;

   tie_bank_if #(.WIDTH(W), .CH(N)) bus_a ();
   tie_bank_if #(.WIDTH(W), .CH(N)) bus_b ();

`ifdef TIE_BANK_PARITY_EN
   logic [N-1:0] par_a;
   logic [N-1:0] par_b;
`endif

   tie_bank #(.WIDTH(W), .CH(N), .RST_VAL(8'h00), .INIT_VAL(8'hA5), .STAGGER(16)) dut_a (
      .iClock (clk),
      .iReset (rst_a),
`ifdef TIE_BANK_PARITY_EN
      .oParity(par_a),
`endif
      .bus    (bus_a)
   );

   tie_bank #(.WIDTH(W), .CH(N), .RST_VAL(8'h00), .INIT_VAL(8'hA5), .STAGGER(0)) dut_b (
      .iClock (clk),
      .iReset (rst_b),
`ifdef TIE_BANK_PARITY_EN
      .oParity(par_b),
`endif
      .bus    (bus_b)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ch_a(input int i);
      return bus_a.oTie[i*8 +: 8];
   endfunction

   task automatic wr_a(input logic vld, input logic [3:0] ch, input logic [7:0] dat);
      bus_a.iWrValid   = vld;
      bus_a.iWrChannel = ch;
      bus_a.iWrData    = dat;
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      wr_a(1'b0, 4'd0, 8'h00);
      bus_a.iLock      = 1'b0;
      bus_b.iWrValid   = 1'b0;
      bus_b.iWrChannel = 4'd0;
      bus_b.iWrData    = 8'h00;
      bus_b.iLock      = 1'b0;
      repeat (3) tick();

      // reset state
      chk("rst_tie",  bus_a.oTie,     32'h0);
      chk("rst_rdy",  bus_a.oWrReady, 1'b0);
      chk("rst_lock", bus_a.oLocked,  1'b0);
      chk("rst_done", bus_a.oSeqDone, 1'b0);
      chk("rst_err",  bus_a.oWrErr,   1'b0);

      // release sequence with a write during SEQ (c=5) and on the ch0 release edge (c=15)
      rst_a = 1'b0;
      for (int c = 0; c <= 70; c++) begin
         chk("seq_rdy",  bus_a.oWrReady, c >= 1);
         chk("seq_ch0",  ch_a(0), c < 16 ? 8'h00 : 8'h11);
         chk("seq_ch1",  ch_a(1), c < 32 ? 8'h00 : 8'hA5);
         chk("seq_ch2",  ch_a(2), c < 48 ? 8'h00 : 8'h3C);
         chk("seq_ch3",  ch_a(3), c < 64 ? 8'h00 : 8'hA5);
         chk("seq_done", bus_a.oSeqDone, c >= 64);
         if (c == 5)       wr_a(1'b1, 4'd2, 8'h3C);
         else if (c == 15) wr_a(1'b1, 4'd0, 8'h11);
         else              wr_a(1'b0, 4'd0, 8'h00);
         tick();
      end

      // write in RUN, visible next cycle
      chk("run_pre", bus_a.oTie, 32'hA53CA511);
      wr_a(1'b1, 4'd3, 8'hFF);
      tick();
      chk("run_wr_ch3", bus_a.oTie, 32'hFF3CA511);
      chk("run_no_err", bus_a.oWrErr, 1'b0);

      // out-of-range channel
      wr_a(1'b1, 4'd7, 8'h55);
      tick();
      chk("err_pulse", bus_a.oWrErr, 1'b1);
      chk("err_tie",   bus_a.oTie,   32'hFF3CA511);
      wr_a(1'b0, 4'd0, 8'h00);
      tick();
      chk("err_clear", bus_a.oWrErr,   1'b0);
      chk("pre_lock",  bus_a.oLocked,  1'b0);
      chk("pre_rdy",   bus_a.oWrReady, 1'b1);

      // lock together with a write: write lands, ready drops
      bus_a.iLock = 1'b1;
      wr_a(1'b1, 4'd1, 8'h22);
      tick();
      chk("lock_set", bus_a.oLocked,  1'b1);
      chk("lock_rdy", bus_a.oWrReady, 1'b0);
      chk("lock_wr",  bus_a.oTie,     32'hFF3C2211);
      bus_a.iLock = 1'b0;
      wr_a(1'b1, 4'd1, 8'h33);
      tick();
      chk("lock_ignore", bus_a.oTie,     32'hFF3C2211);
      chk("lock_sticky", bus_a.oLocked,  1'b1);
      chk("lock_rdy2",   bus_a.oWrReady, 1'b0);
      wr_a(1'b0, 4'd0, 8'h00);

      // reset from RUN/locked
      rst_a = 1'b1;
      tick();
      chk("rst2_tie",  bus_a.oTie,     32'h0);
      chk("rst2_lock", bus_a.oLocked,  1'b0);
      chk("rst2_rdy",  bus_a.oWrReady, 1'b0);
      chk("rst2_done", bus_a.oSeqDone, 1'b0);

      // second run: write ch0 before release, then reset mid-sequence at c=30
      rst_a = 1'b0;
      for (int c = 0; c <= 30; c++) begin
         if (c == 15) chk("mid_ch0_pre",  ch_a(0), 8'h00);
         if (c == 16) chk("mid_ch0_rel",  ch_a(0), 8'h77);
         if (c == 30) chk("mid_ch1_hold", ch_a(1), 8'h00);
         if (c == 10) wr_a(1'b1, 4'd0, 8'h77);
         else         wr_a(1'b0, 4'd0, 8'h00);
         rst_a = (c == 30);
         tick();
      end
      chk("mid_tie",  bus_a.oTie,     32'h0);
      chk("mid_rdy",  bus_a.oWrReady, 1'b0);
      chk("mid_done", bus_a.oSeqDone, 1'b0);

      // restart: shadows are back to INIT_VAL, schedule from zero
      rst_a = 1'b0;
      for (int c = 0; c <= 33; c++) begin
         chk("rs_rdy", bus_a.oWrReady, c >= 1);
         chk("rs_ch0", ch_a(0), c < 16 ? 8'h00 : 8'hA5);
         chk("rs_ch1", ch_a(1), c < 32 ? 8'h00 : 8'hA5);
         tick();
      end

      // STAGGER = 0 instance
      chk("b_rst_tie",  bus_b.oTie,     32'h0);
      chk("b_rst_done", bus_b.oSeqDone, 1'b0);
`ifdef TIE_BANK_PARITY_EN
      chk("b_rst_par",  par_b,          4'b0000);
`endif
      rst_b = 1'b0;
      tick();
      chk("b_all_rel", bus_b.oTie,     32'hA5A5A5A5);
      chk("b_done",    bus_b.oSeqDone, 1'b1);
      chk("b_rdy",     bus_b.oWrReady, 1'b1);
`ifdef TIE_BANK_PARITY_EN
      chk("b_par",     par_b,          4'b0000);
`endif
      bus_b.iWrValid   = 1'b1;
      bus_b.iWrChannel = 4'd0;
      bus_b.iWrData    = 8'h01;
      tick();
      bus_b.iWrValid = 1'b0;
      chk("b_wr_ch0", bus_b.oTie, 32'hA5A5A501);
`ifdef TIE_BANK_PARITY_EN
      chk("b_par_wr", par_b,      4'b0001);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
